clk_div_monitor: RTL and testbench

Receiving-end checker for divided clocks from the clock-divider blocks. Samples a divided clock on the fast source clock, measures period and high time in source-clock cycles, and compares the period against an expected ratio. Reports lock after consecutive good periods, flags ratio errors, and detects a stopped clock. Sits beside each divider instance as a built-in self-check and a bring-up aid.

---
 rtl/clk_div_monitor.sv | 211 +++++++++++++++++++++
 tb/tb_clk_div_monitor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// Divided-clock checker: measures period/high time of clk_div_in in clk cycles and tracks lock, ratio errors and loss.
// Optional CLKMON_SYNC_EN adds a 2-flop synchronizer in front of the sampling flop.
module clk_div_monitor #(
    parameter int DIV      = 2,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 64,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clk_div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_vld,
    output logic             locked,
    output logic             err,
    output logic             lost,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_ACQ    = 3'd2,
        S_LOCKED = 3'd3,
        S_LOST   = 3'd4
    } state_t;

    localparam int               GW        = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0]    LOCK_V    = GW'(LOCK_CNT);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   DIV_V     = (CNT_W+1)'(DIV);
    localparam logic [CNT_W:0]   TOL_V     = (CNT_W+1)'(TOL);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [GW-1:0]     r_good_cnt;
    logic [GW-1:0]     w_good_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_hcnt;
    logic [CNT_W-1:0]  r_period;
    logic [CNT_W-1:0]  r_high_time;
    logic              r_period_vld;
    logic              r_err;
    logic              r_s0;
    logic              r_s0_d;
    logic              w_samp;
    logic              w_rise;
    logic              w_timeout;
    logic              w_good;
    logic              w_capture;
    logic              w_bad;
    logic signed [CNT_W:0] w_diff;
    logic [CNT_W:0]    w_abs;

`ifdef CLKMON_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= clk_div_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_samp = r_sync2;
`else
    assign w_samp = clk_div_in;
`endif

    assign w_rise    = r_s0 & ~r_s0_d;
    assign w_timeout = (r_cnt >= TIMEOUT_V);
    // One extra bit keeps cnt - DIV signed without wrapping for any counter value.
    assign w_diff    = $signed({1'b0, r_cnt}) - $signed(DIV_V);
    assign w_abs     = w_diff[CNT_W] ? ((~w_diff) + (CNT_W+1)'(1)) : w_diff;
    assign w_good    = (w_abs <= TOL_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_good_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_capture   = 1'b0;
        w_bad       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_good_nxt = '0;
                w_state_nxt = S_ARM;
            end
            S_ARM: begin
                if (w_rise) begin
                    w_state_nxt = S_ACQ;
                end else if (w_timeout) begin
                    w_state_nxt = S_LOST;
                end
            end
            S_ACQ: begin
                if (w_rise) begin
                    w_capture = 1'b1;
                    if (w_good) begin
                        w_good_nxt = r_good_cnt + 1'b1;
                        if (r_good_cnt + 1'b1 >= LOCK_V) begin
                            w_state_nxt = S_LOCKED;
                        end
                    end else begin
                        w_good_nxt = '0;
                        w_bad      = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_good_nxt  = '0;
                    w_state_nxt = S_LOST;
                end
            end
            S_LOCKED: begin
                if (w_rise) begin
                    w_capture = 1'b1;
                    if (!w_good) begin
                        w_bad       = 1'b1;
                        w_good_nxt  = '0;
                        w_state_nxt = S_ACQ;
                    end
                end else if (w_timeout) begin
                    w_good_nxt  = '0;
                    w_state_nxt = S_LOST;
                end
            end
            S_LOST: begin
                w_good_nxt = '0;
                if (w_rise) begin
                    w_state_nxt = S_ACQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_good_nxt  = '0;
            end
        endcase
        // Disable overrides everything, including a rise in the same cycle.
        if (!en) begin
            w_state_nxt = S_IDLE;
            w_good_nxt  = '0;
            w_capture   = 1'b0;
            w_bad       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0         <= 1'b0;
            r_s0_d       <= 1'b0;
            r_cnt        <= '0;
            r_hcnt       <= '0;
            r_period     <= '0;
            r_high_time  <= '0;
            r_period_vld <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_s0   <= w_samp;
            r_s0_d <= r_s0;
            if (!en || r_state == S_IDLE) begin
                r_cnt        <= '0;
                r_hcnt       <= '0;
                r_period     <= '0;
                r_high_time  <= '0;
                r_period_vld <= 1'b0;
                r_err        <= 1'b0;
            end else begin
                r_period_vld <= w_capture;
                r_err        <= w_bad;
                if (w_capture) begin
                    r_period    <= r_cnt;
                    r_high_time <= r_hcnt;
                end
                if (w_rise) begin
                    r_cnt  <= CNT_W'(1);
                    r_hcnt <= CNT_W'(1);
                end else begin
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (r_s0 && r_hcnt != '1) begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
            end
        end
    end

    assign period     = r_period;
    assign high_time  = r_high_time;
    assign period_vld = r_period_vld;
    assign err        = r_err;
    assign locked     = (r_state == S_LOCKED);
    assign lost       = (r_state == S_LOST);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: directed divided-clock waveforms with hand-computed captures fed to
// per-instance expected queues; negedge monitors pop and compare on every period_vld.
module tb_clk_div_monitor;

`ifdef CLKMON_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk;
    logic        rst;
    logic        en_a;
    logic        en_b;
    logic        div_a;
    logic        div_b;
    logic [15:0] period_a;
    logic [15:0] high_a;
    logic        vld_a;
    logic        locked_a;
    logic        err_a;
    logic        lost_a;
    logic [2:0]  dbg_a;
    logic [15:0] period_b;
    logic [15:0] high_b;
    logic        vld_b;
    logic        locked_b;
    logic        err_b;
    logic        lost_b;
    logic [2:0]  dbg_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int a_vld_cyc = -1;
    logic [33:0] exp_a[$];
    logic [33:0] exp_b[$];

    clk_div_monitor u_a (
        .clk(clk), .rst(rst), .en(en_a), .clk_div_in(div_a),
        .period(period_a), .high_time(high_a), .period_vld(vld_a),
        .locked(locked_a), .err(err_a), .lost(lost_a), .dbg_state(dbg_a)
    );

    clk_div_monitor #(.DIV(4)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .clk_div_in(div_b),
        .period(period_b), .high_time(high_b), .period_vld(vld_b),
        .locked(locked_b), .err(err_b), .lost(lost_b), .dbg_state(dbg_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int id, input logic v);
        if (id == 0) div_a = v;
        else div_b = v;
    endtask

    // Drives one period (hi cycles high, lo low). The rising edge that starts it completes
    // the previous period; when cap is set that capture is expected with the given values.
    task automatic drive_period(input int id, input int hi, input int lo, input bit cap,
                                input int ep, input int eh, input bit eerr, input bit elock);
        logic [31:0] p;
        logic [31:0] h;
        logic [33:0] e;
        p = ep;
        h = eh;
        e = {p[15:0], h[15:0], eerr, elock};
        if (cap) begin
            if (id == 0) exp_a.push_back(e);
            else exp_b.push_back(e);
        end
        last_rise_cyc = cyc;
        set_in(id, 1'b1);
        wait_cyc(hi);
        set_in(id, 1'b0);
        wait_cyc(lo);
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        logic [33:0] e;
        if (vld_a) begin
            a_vld_cyc = cyc;
            if (exp_a.size() == 0) begin
                check("a_unexpected_capture", 32'(period_a), 32'hFFFF_FFFF);
            end else begin
                e = exp_a.pop_front();
                check("a_period", 32'(period_a), 32'(e[33:18]));
                check("a_high_time", 32'(high_a), 32'(e[17:2]));
                check("a_err", 32'(err_a), 32'(e[1]));
                check("a_locked", 32'(locked_a), 32'(e[0]));
            end
        end else if (err_a) begin
            check("a_err_without_vld", 32'(err_a), 32'd0);
        end
        if (vld_b) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_capture", 32'(period_b), 32'hFFFF_FFFF);
            end else begin
                e = exp_b.pop_front();
                check("b_period", 32'(period_b), 32'(e[33:18]));
                check("b_high_time", 32'(high_b), 32'(e[17:2]));
                check("b_err", 32'(err_b), 32'(e[1]));
                check("b_locked", 32'(locked_b), 32'(e[0]));
            end
        end
    end

    task automatic check_all_zero_a(input string tag);
        check({tag, "_period"}, 32'(period_a), 0);
        check({tag, "_high_time"}, 32'(high_a), 0);
        check({tag, "_vld"}, 32'(vld_a), 0);
        check({tag, "_locked"}, 32'(locked_a), 0);
        check({tag, "_err"}, 32'(err_a), 0);
        check({tag, "_lost"}, 32'(lost_a), 0);
    endtask

    initial begin
        int target;
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; div_a = 1'b0; div_b = 1'b0;
        wait_cyc(3);
        check_all_zero_a("rst");
        check("rst_dbg", 32'(dbg_a), 0);
        check("rst_b_locked", 32'(locked_b), 0);
        check("rst_b_lost", 32'(lost_b), 0);
        rst = 1'b0;

        // clean divide-by-2: lock on the 4th capture
        en_a = 1'b1;
        wait_cyc(2);
        for (int i = 0; i < 8; i++) drive_period(0, 1, 1, i > 0, 2, 1, 0, i >= 4);

        // glitch: one stretched period, then relock after 4 good ones
        drive_period(0, 1, 2, 1, 2, 1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive_period(0, 1, 1, 1, 3, 1, 1, 0);
            else drive_period(0, 1, 1, 1, 2, 1, 0, i == 4);
        end

        // stopped clock: last edge, then hold low
        drive_period(0, 1, 1, 1, 2, 1, 0, 1);
        target = last_rise_cyc + 65 + LAT;
        wait_cyc(target - cyc);
        check("lost_before_timeout", 32'(lost_a), 0);
        check("locked_before_timeout", 32'(locked_a), 1);
        wait_cyc(1);
        check("lost_at_timeout", 32'(lost_a), 1);
        check("locked_at_timeout", 32'(locked_a), 0);

        // restart: first edge clears lost without capture, relock on 5th edge
        for (int i = 0; i < 6; i++) begin
            drive_period(0, 1, 1, i > 0, 2, 1, 0, i >= 4);
            if (i == 2) check("lost_cleared", 32'(lost_a), 0);
        end
        wait_cyc(4);
        check("relocked_level", 32'(locked_a), 1);
        check("relocked_period", 32'(period_a), 2);

        // asynchronous reset while locked
        #1 rst = 1'b1;
        #1 check_all_zero_a("async_rst");
        en_a = 1'b0;
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(1);

        // enable drop mid-acquisition, plus first-capture latency
        en_a = 1'b1;
        wait_cyc(2);
        drive_period(0, 1, 1, 0, 0, 0, 0, 0);
        drive_period(0, 1, 1, 1, 2, 1, 0, 0);
        target = last_rise_cyc + 2 + LAT;
        wait_cyc(4);
        check("first_capture_latency", 32'(a_vld_cyc), 32'(target));
        check("acq_period", 32'(period_a), 2);
        check("acq_high_time", 32'(high_a), 1);
        en_a = 1'b0;
        wait_cyc(1);
        check_all_zero_a("en_drop");

        // ratio mismatch on the DIV=4 instance
        en_b = 1'b1;
        wait_cyc(2);
        for (int i = 0; i < 5; i++) drive_period(1, 3, 3, i > 0, 6, 3, 1, 0);
        wait_cyc(6);
        check("b_not_locked", 32'(locked_b), 0);
        en_b = 1'b0;

        wait_cyc(4);
        check("exp_a_drained", 32'(exp_a.size()), 0);
        check("exp_b_drained", 32'(exp_b.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
